// File: rtl/code_lock_if.sv
// Keypad-to-lock bus: key code/strobe from the scanner, lock status back.
// The lock drives the slave side; the scanner side uses master.
interface code_lock_if;
    logic [3:0] N;
    logic       V;
    logic       UNLOCK;
    logic       ALARM;
    logic       ERR;
    logic [2:0] CNT;

    modport master (
        output N,
        output V,
        input  UNLOCK,
        input  ALARM,
        input  ERR,
        input  CNT
    );

    modport slave (
        input  N,
        input  V,
        output UNLOCK,
        output ALARM,
        output ERR,
        output CNT
    );
endinterface

// File: rtl/code_lock.sv
// PIN entry controller with failed-attempt lockout and timed unlock.
// Define LOCK_PROG_EN to allow reprogramming the PIN while the lock is open.
module code_lock #(
    parameter int                    DIGITS         = 4,
    parameter logic [4*DIGITS-1:0]   DEFAULT_CODE   = 16'h1234,
    parameter int                    MAX_TRIES      = 3,
    parameter int                    UNLOCK_CYCLES  = 1000,
    parameter int                    LOCKOUT_CYCLES = 5000
) (
    input  logic         CLK,
    input  logic         RST,
    code_lock_if.slave   bus
);

    localparam int         BW       = 4 * DIGITS;
    localparam int         FW       = $clog2(MAX_TRIES + 1);
    localparam logic [2:0] CNT_FULL = 3'(DIGITS);
    localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_TRIES);

    typedef enum logic [2:0] {
        ENTRY   = 3'd0,
        CHECK   = 3'd1,
        OPEN    = 3'd2,
        LOCKOUT = 3'd3
`ifdef LOCK_PROG_EN
        ,PROG   = 3'd4
`endif
    } state_t;

    state_t          state_reg, state_next;
    logic [BW-1:0]   buf_reg, buf_next;
    logic [2:0]      cnt_reg, cnt_next;
    logic [FW-1:0]   fail_reg, fail_next;
    logic [31:0]     timer_reg, timer_next;
    logic            err_reg, err_next;
    logic [BW-1:0]   code_w;

    // Key decode: only strobed keys count, codes 12..15 fall through as no-ops.
    logic key_digit, key_star, key_enter;
    assign key_digit = bus.V && (bus.N <= 4'd9);
    assign key_star  = bus.V && (bus.N == 4'd10);
    assign key_enter = bus.V && (bus.N == 4'd11);

    logic [BW-1:0] buf_shift;
    logic          cnt_full;
    assign buf_shift = (buf_reg << 4) | BW'(bus.N);
    assign cnt_full  = (cnt_reg == CNT_FULL);

`ifdef LOCK_PROG_EN
    logic [BW-1:0] code_reg, code_next;
    assign code_w = code_reg;
`else
    assign code_w = DEFAULT_CODE;
`endif

    // Per-digit comparison against the stored code.
    logic [DIGITS-1:0] nib_eq;
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
            assign nib_eq[gi] = (buf_reg[4*gi +: 4] == code_w[4*gi +: 4]);
        end
    endgenerate

    logic          pin_match;
    logic [FW-1:0] fail_inc;
    assign pin_match = cnt_full && (&nib_eq);
    assign fail_inc  = (fail_reg == FAIL_MAX) ? fail_reg : fail_reg + FW'(1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= ENTRY;
            buf_reg   <= '0;
            cnt_reg   <= '0;
            fail_reg  <= '0;
            timer_reg <= '0;
            err_reg   <= 1'b0;
`ifdef LOCK_PROG_EN
            code_reg  <= DEFAULT_CODE;
`endif
        end else begin
            state_reg <= state_next;
            buf_reg   <= buf_next;
            cnt_reg   <= cnt_next;
            fail_reg  <= fail_next;
            timer_reg <= timer_next;
            err_reg   <= err_next;
`ifdef LOCK_PROG_EN
            code_reg  <= code_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        buf_next   = buf_reg;
        cnt_next   = cnt_reg;
        fail_next  = fail_reg;
        timer_next = timer_reg;
        err_next   = 1'b0;
`ifdef LOCK_PROG_EN
        code_next  = code_reg;
`endif
        case (state_reg)
            ENTRY: begin
                if (key_digit) begin
                    if (!cnt_full) begin
                        buf_next = buf_shift;
                        cnt_next = cnt_reg + 3'd1;
                    end
                end else if (key_star) begin
                    buf_next = '0;
                    cnt_next = '0;
                end else if (key_enter) begin
                    state_next = CHECK;
                end
            end

            CHECK: begin
                buf_next = '0;
                cnt_next = '0;
                if (pin_match) begin
                    state_next = OPEN;
                    fail_next  = '0;
                    timer_next = 32'(UNLOCK_CYCLES);
                end else begin
                    err_next  = 1'b1;
                    fail_next = fail_inc;
                    if (fail_inc == FAIL_MAX) begin
                        state_next = LOCKOUT;
                        timer_next = 32'(LOCKOUT_CYCLES);
                    end else begin
                        state_next = ENTRY;
                    end
                end
            end

            OPEN: begin
                if (key_enter) begin
                    state_next = ENTRY;
                    timer_next = '0;
                end
`ifdef LOCK_PROG_EN
                else if (key_star) begin
                    state_next = PROG;
                    buf_next   = '0;
                    cnt_next   = '0;
                end
`endif
                else begin
                    timer_next = timer_reg - 32'd1;
                    if (timer_reg == 32'd1)
                        state_next = ENTRY;
                end
            end

            LOCKOUT: begin
                timer_next = timer_reg - 32'd1;
                if (timer_reg == 32'd1) begin
                    state_next = ENTRY;
                    fail_next  = '0;
                end
            end

`ifdef LOCK_PROG_EN
            // Timer is frozen here; leaving always relocks.
            PROG: begin
                if (key_digit) begin
                    if (!cnt_full) begin
                        buf_next = buf_shift;
                        cnt_next = cnt_reg + 3'd1;
                    end
                end else if (key_enter) begin
                    if (cnt_full)
                        code_next = buf_reg;
                    state_next = ENTRY;
                    buf_next   = '0;
                    cnt_next   = '0;
                    timer_next = '0;
                end else if (key_star) begin
                    state_next = ENTRY;
                    buf_next   = '0;
                    cnt_next   = '0;
                    timer_next = '0;
                end
            end
`endif

            default: begin
                state_next = ENTRY;
            end
        endcase
    end

`ifdef LOCK_PROG_EN
    assign bus.UNLOCK = (state_reg == OPEN) || (state_reg == PROG);
`else
    assign bus.UNLOCK = (state_reg == OPEN);
`endif
    assign bus.ALARM = (state_reg == LOCKOUT);
    assign bus.ERR   = err_reg;
    assign bus.CNT   = cnt_reg;

endmodule

// File: tb/tb_code_lock.sv
// Directed bench for code_lock with short unlock/lockout timers.
// Expectations for the reprogramming sequence follow LOCK_PROG_EN.
module tb_code_lock;

    localparam int UC = 8;
    localparam int LC = 12;

    logic CLK;
    logic RST;
    int   checks;
    int   errors;

    code_lock_if bus ();

    code_lock #(
        .DIGITS        (4),
        .DEFAULT_CODE  (16'h1234),
        .MAX_TRIES     (3),
        .UNLOCK_CYCLES (UC),
        .LOCKOUT_CYCLES(LC)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; the key is sampled on the next rising edge.
    task automatic key(input logic [3:0] k);
        bus.N = k;
        bus.V = 1'b1;
        @(negedge CLK);
        bus.V = 1'b0;
        bus.N = 4'd0;
    endtask

    task automatic pin(input logic [15:0] p);
        logic [15:0] q;
        q = p;
        for (int i = 3; i >= 0; i--) key(q[4*i +: 4]);
        key(4'd11);
    endtask

    task automatic wrong_and_check(input string tag);
        pin(16'h9999);
        @(negedge CLK);
        chk(tag, bus.ERR, 1);
    endtask

    initial begin
        int          hi;
        int          err_seen;
        int          unl_seen;
        logic [15:0] lock_pin;
        logic        exp_a_open;
        logic        exp_b_open;

        checks = 0;
        errors = 0;
        RST    = 1'b1;
        bus.N  = 4'd0;
        bus.V  = 1'b0;
        lock_pin = 16'h1234;
        repeat (2) @(negedge CLK);
        chk("rst_cnt",    bus.CNT, 0);
        chk("rst_unlock", bus.UNLOCK, 0);
        chk("rst_alarm",  bus.ALARM, 0);
        chk("rst_err",    bus.ERR, 0);
        RST = 1'b0;
        @(negedge CLK);

        // Correct PIN and unlock duration
        for (int i = 3; i >= 0; i--) begin
            key(lock_pin[4*i +: 4]);
            chk("cnt_inc", bus.CNT, 4 - i);
        end
        key(4'd11);
        chk("check_cycle_unlock", bus.UNLOCK, 0);
        @(negedge CLK);
        chk("open_unlock", bus.UNLOCK, 1);
        chk("open_err", bus.ERR, 0);
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            if (!bus.UNLOCK) break;
            hi++;
            @(negedge CLK);
        end
        chk("unlock_len", hi, UC);
        chk("post_open_cnt", bus.CNT, 0);

        // Short PIN rejected
        key(4'd1); key(4'd2); key(4'd3); key(4'd11);
        chk("short_err_check", bus.ERR, 0);
        @(negedge CLK);
        chk("short_err", bus.ERR, 1);
        chk("short_unlock", bus.UNLOCK, 0);
        @(negedge CLK);
        chk("short_err_one", bus.ERR, 0);

        // Fifth digit dropped, then opens; '#' relocks
        key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
        chk("drop_cnt", bus.CNT, 4);
        key(4'd11);
        @(negedge CLK);
        chk("drop_open", bus.UNLOCK, 1);
        key(4'd11);
        chk("relock", bus.UNLOCK, 0);

        // Lockout after three wrong PINs
        wrong_and_check("wrong1_err");
        chk("wrong1_alarm", bus.ALARM, 0);
        wrong_and_check("wrong2_err");
        chk("wrong2_alarm", bus.ALARM, 0);
        wrong_and_check("wrong3_err");
        chk("wrong3_alarm", bus.ALARM, 1);
        hi = 0;
        err_seen = 0;
        unl_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (!bus.ALARM) break;
            hi++;
            if (i > 0 && bus.ERR) err_seen++;
            if (bus.UNLOCK) unl_seen++;
            if (i < 4) begin
                bus.N = lock_pin[4*(3-i) +: 4];
                bus.V = 1'b1;
            end else if (i == 4) begin
                bus.N = 4'd11;
                bus.V = 1'b1;
            end else begin
                bus.N = 4'd0;
                bus.V = 1'b0;
            end
            @(negedge CLK);
        end
        bus.V = 1'b0;
        chk("alarm_len", hi, LC);
        chk("lockout_no_unlock", unl_seen, 0);
        chk("lockout_no_err", err_seen, 0);
        chk("lockout_cnt", bus.CNT, 0);
        pin(lock_pin);
        @(negedge CLK);
        chk("after_lockout_open", bus.UNLOCK, 1);
        key(4'd11);

        // Clear mid-entry
        key(4'd1);  chk("clr_cnt1", bus.CNT, 1);
        key(4'd2);  chk("clr_cnt2", bus.CNT, 2);
        key(4'd10); chk("clr_cnt0", bus.CNT, 0);
        for (int i = 3; i >= 0; i--) begin
            key(lock_pin[4*i +: 4]);
            chk("clr_cnt_re", bus.CNT, 4 - i);
        end
        key(4'd11);
        @(negedge CLK);
        chk("clr_open", bus.UNLOCK, 1);
        key(4'd11);
        chk("clr_relock", bus.UNLOCK, 0);

        // Reprogramming attempt while open
        pin(lock_pin);
        @(negedge CLK);
        chk("prog_open", bus.UNLOCK, 1);
        key(4'd10);
        chk("prog_star_unlock", bus.UNLOCK, 1);
        key(4'd5); key(4'd6); key(4'd7); key(4'd8);
        chk("prog_digits_unlock", bus.UNLOCK, 1);
        key(4'd11);
        chk("prog_exit_locked", bus.UNLOCK, 0);
`ifdef LOCK_PROG_EN
        exp_a_open = 1'b0;
        exp_b_open = 1'b1;
`else
        exp_a_open = 1'b1;
        exp_b_open = 1'b0;
`endif
        pin(16'h1234);
        @(negedge CLK);
        chk("old_code_unlock", bus.UNLOCK, exp_a_open);
        chk("old_code_err", bus.ERR, !exp_a_open);
        if (exp_a_open) key(4'd11);
        @(negedge CLK);
        pin(16'h5678);
        @(negedge CLK);
        chk("new_code_unlock", bus.UNLOCK, exp_b_open);
        chk("new_code_err", bus.ERR, !exp_b_open);
        if (exp_b_open) key(4'd11);
        @(negedge CLK);

        // Reset mid-entry
        key(4'd1); key(4'd2);
        chk("mid_cnt", bus.CNT, 2);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("mid_rst_cnt", bus.CNT, 0);

        // Reset during alarm, then default code works again
        wrong_and_check("rw1_err");
        wrong_and_check("rw2_err");
        wrong_and_check("rw3_err");
        chk("rw3_alarm", bus.ALARM, 1);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("alarm_rst_alarm",  bus.ALARM, 0);
        chk("alarm_rst_unlock", bus.UNLOCK, 0);
        chk("alarm_rst_cnt",    bus.CNT, 0);
        pin(16'h1234);
        @(negedge CLK);
        chk("default_restored", bus.UNLOCK, 1);
        key(4'd11);
        chk("final_relock", bus.UNLOCK, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
